// File: rtl/ps2_host_transmitter.sv
// ---------------------------------------------------------------------------
// ps2_host_transmitter
//
// Sends one command byte from the host to a PS/2 device using the
// host-request protocol. The host inhibits the bus, then issues a request
// (data low, clock released). After that it follows the device-generated
// clock and presents one bit per falling edge. Both open-drain lines are
// controlled through active-high "drive low" enables.
//
// Ports
//   clock                in   system clock
//   reset                in   synchronous, active-high reset
//   ps2_clock            in   PS/2 clock line, read back
//   ps2_data             in   PS/2 data line, read back
//   start                in   send request, accepted only while ready=1
//   tx_data[7:0]         in   command byte, latched on start accept
//   ready                out  high while idle
//   done                 out  one-cycle pulse: byte sent and ACK seen
//   error                out  one-cycle pulse: no ACK, or timeout
//   ps2_clock_drive_low  out  1 = pull the clock line low
//   ps2_data_drive_low   out  1 = pull the data line low
// ---------------------------------------------------------------------------
module ps2_host_transmitter #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clock,
  input  logic       ps2_data,
  input  logic       start,
  input  logic [7:0] tx_data,
  output logic       ready,
  output logic       done,
  output logic       error,
  output logic       ps2_clock_drive_low,
  output logic       ps2_data_drive_low
);

  // The inhibit period and the timeout share one 20-bit counter; the
  // counter is cleared when START is entered, so the two never overlap.
  localparam logic [19:0] INHIBIT_LAST = 20'(INHIBIT_CYCLES - 1);
  localparam logic [19:0] TIMEOUT_LAST = 20'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_INHIBIT = 3'd1,
    S_START   = 3'd2,
    S_REQUEST = 3'd3,
    S_DATA    = 3'd4,
    S_STOP    = 3'd5,
    S_ACK     = 3'd6
  } state_t;

  state_t      state;
  logic [9:0]  clk_hist_p0;
  logic        fall_p0;
  logic [19:0] cycle_cnt;
  logic [3:0]  bit_cnt;
  logic [8:0]  shift_reg;

  // Odd parity: the parity bit makes the total count of ones in
  // {parity, data} odd.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

  // ---- stage p0: ps2_clock history and filtered falling edge ----
  // Newest sample enters at bit 9. An edge is recognised only after five
  // consecutive high samples followed by five consecutive low samples, so
  // short glitches on the line never advance the frame.
  always_ff @(posedge clock) begin
    if (reset) begin
      clk_hist_p0 <= '0;
    end else begin
      clk_hist_p0 <= {ps2_clock, clk_hist_p0[9:1]};
    end
  end

  assign fall_p0 = (clk_hist_p0[4:0] == 5'b11111) && (clk_hist_p0[9:5] == 5'b00000);

  // ---- stage p1: frame FSM with registered outputs ----
  // The shift register is pure datapath: it is always loaded before use,
  // so it carries no reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state               <= S_IDLE;
      ready               <= 1'b1;
      done                <= 1'b0;
      error               <= 1'b0;
      ps2_clock_drive_low <= 1'b0;
      ps2_data_drive_low  <= 1'b0;
      cycle_cnt           <= '0;
      bit_cnt             <= '0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;

      unique case (state)
        S_IDLE: begin
          ready               <= 1'b1;
          ps2_clock_drive_low <= 1'b0;
          ps2_data_drive_low  <= 1'b0;
          if (start) begin
            shift_reg           <= {odd_parity(tx_data), tx_data};
            bit_cnt             <= '0;
            cycle_cnt           <= '0;
            ready               <= 1'b0;
            ps2_clock_drive_low <= 1'b1;
            state               <= S_INHIBIT;
          end
        end

        S_INHIBIT: begin
          if (cycle_cnt == INHIBIT_LAST) begin
            cycle_cnt          <= '0;
            ps2_data_drive_low <= 1'b1;
            state              <= S_START;
          end else begin
            cycle_cnt <= cycle_cnt + 20'd1;
          end
        end

        S_START: begin
          // Releasing the clock with data held low is the request; the
          // low data line doubles as the start bit.
          ps2_clock_drive_low <= 1'b0;
          state               <= S_REQUEST;
        end

        S_REQUEST, S_DATA, S_STOP, S_ACK: begin
          if (cycle_cnt == TIMEOUT_LAST) begin
            // The device stopped clocking: give the bus back and report.
            ps2_clock_drive_low <= 1'b0;
            ps2_data_drive_low  <= 1'b0;
            error               <= 1'b1;
            ready               <= 1'b1;
            state               <= S_IDLE;
          end else begin
            cycle_cnt <= cycle_cnt + 20'd1;
            if (fall_p0) begin
              unique case (state)
                S_REQUEST: begin
                  ps2_data_drive_low <= ~shift_reg[0];
                  shift_reg          <= {1'b0, shift_reg[8:1]};
                  bit_cnt            <= 4'd1;
                  state              <= S_DATA;
                end
                S_DATA: begin
                  // bit_cnt holds the number of bits already presented;
                  // at 8 this edge presents the parity bit.
                  ps2_data_drive_low <= ~shift_reg[0];
                  shift_reg          <= {1'b0, shift_reg[8:1]};
                  bit_cnt            <= bit_cnt + 4'd1;
                  if (bit_cnt == 4'd8) begin
                    state <= S_STOP;
                  end
                end
                S_STOP: begin
                  ps2_data_drive_low <= 1'b0;
                  state              <= S_ACK;
                end
                default: begin
                  // Device pulls data low to acknowledge the frame.
                  if (!ps2_data) begin
                    done <= 1'b1;
                  end else begin
                    error <= 1'b1;
                  end
                  ps2_data_drive_low <= 1'b0;
                  ready              <= 1'b1;
                  state              <= S_IDLE;
                end
              endcase
            end
          end
        end

        default: begin
          ps2_clock_drive_low <= 1'b0;
          ps2_data_drive_low  <= 1'b0;
          ready               <= 1'b1;
          state               <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_transmitter.sv
// ---------------------------------------------------------------------------
// tb_ps2_host_transmitter
//
// Bench for ps2_host_transmitter. A device model generates the PS/2 clock,
// records the data line on every rising clock edge (the request release
// counts as the first), and optionally acknowledges. Expected frames are
// built from the byte value by counting ones.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ps2_host_transmitter;

  localparam int INHIBIT = 20;
  localparam int TIMEOUT = 2000;
  localparam int HALF    = 40;

  logic       clock   = 1'b0;
  logic       reset   = 1'b1;
  logic       start   = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       ready, done, error;
  logic       cdl, ddl;

  logic dev_clk_low  = 1'b0;
  logic dev_data_low = 1'b0;
  logic ps2_clock_line, ps2_data_line;

  // Open-drain lines with pull-ups.
  assign ps2_clock_line = ~(cdl | dev_clk_low);
  assign ps2_data_line  = ~(ddl | dev_data_low);

  ps2_host_transmitter #(
    .INHIBIT_CYCLES(INHIBIT),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clock               (clock),
    .reset               (reset),
    .ps2_clock           (ps2_clock_line),
    .ps2_data            (ps2_data_line),
    .start               (start),
    .tx_data             (tx_data),
    .ready               (ready),
    .done                (done),
    .error               (error),
    .ps2_clock_drive_low (cdl),
    .ps2_data_drive_low  (ddl)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_bad = 0;

  // Pulse monitor.
  int   n_done = 0;
  int   n_err  = 0;
  int   n_wide = 0;
  logic done_q = 1'b0;
  logic err_q  = 1'b0;
  logic pulse_ready = 1'b0;
  logic [1:0] pulse_drv = 2'b00;

  always @(negedge clock) begin
    if (done) n_done <= n_done + 1;
    if (error) n_err <= n_err + 1;
    if ((done && done_q) || (error && err_q)) n_wide <= n_wide + 1;
    if (done || error) begin
      pulse_ready <= ready;
      pulse_drv   <= {cdl, ddl};
    end
    done_q <= done;
    err_q  <= error;
  end

  logic [10:0] got_bits;
  int          got_n;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference frame: start 0, data LSB first, odd parity, stop 1.
  function automatic logic [10:0] frame_bits(input logic [7:0] d);
    logic [10:0] f;
    int ones;
    ones = 0;
    f    = '0;
    for (int i = 0; i < 8; i++) begin
      ones += int'((d >> i) & 8'd1);
      f[i+1] = ((d >> i) & 8'd1) != 0;
    end
    f[9]  = (ones % 2) == 0;
    f[10] = 1'b1;
    return f;
  endfunction

  // Device side: waits for the request, then produces nclk clock pulses.
  task automatic dev_frame(input int nclk, input bit ack, input bit glitch, output bit ok);
    int w;
    w        = 0;
    ok       = 1'b1;
    got_n    = 0;
    got_bits = '0;
    while (!(ddl && !cdl) && w < INHIBIT + 200) begin
      @(negedge clock);
      w++;
    end
    if (!(ddl && !cdl)) begin
      ok = 1'b0;
      return;
    end
    got_bits[0] = ps2_data_line;
    got_n = 1;
    for (int k = 1; k <= nclk; k++) begin
      repeat (HALF) @(negedge clock);
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clock);
      dev_clk_low = 1'b0;
      if (k <= 10) begin
        got_bits[k] = ps2_data_line;
        got_n++;
      end
      if (k == 10 && ack) dev_data_low = 1'b1;
      if (k == 3 && glitch) begin
        repeat (8) @(negedge clock);
        dev_clk_low = 1'b1;
        repeat (3) @(negedge clock);
        dev_clk_low = 1'b0;
      end
    end
    repeat (HALF) @(negedge clock);
    dev_data_low = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit ack, input bit glitch,
                            input bit busy_start, input string tag);
    bit ok;
    int d0, e0;
    d0 = n_done;
    e0 = n_err;
    fork
      dev_frame(11, ack, glitch, ok);
      begin
        int inh, st;
        @(negedge clock);
        start   = 1'b1;
        tx_data = d;
        @(negedge clock);
        start   = 1'b0;
        tx_data = ~d;
        check_eq({tag, "_ready_low"}, 32'(ready), 32'd0);
        check_eq({tag, "_clk_drive"}, 32'(cdl), 32'd1);
        inh = 0;
        while (cdl && !ddl && inh < INHIBIT + 50) begin
          inh++;
          @(negedge clock);
        end
        check_eq({tag, "_inhibit_len"}, 32'(inh), 32'(INHIBIT));
        st = 0;
        while (cdl && ddl && st < 10) begin
          st++;
          @(negedge clock);
        end
        check_eq({tag, "_start_len"}, 32'(st), 32'd1);
        if (busy_start) begin
          repeat (300) @(negedge clock);
          start   = 1'b1;
          tx_data = 8'h55;
          @(negedge clock);
          start   = 1'b0;
        end
      end
    join
    repeat (20) @(negedge clock);
    check_eq({tag, "_request"}, 32'(ok), 32'd1);
    check_eq({tag, "_bits"}, 32'(got_bits), 32'(frame_bits(d)));
    check_eq({tag, "_done_cnt"}, 32'(n_done - d0), ack ? 32'd1 : 32'd0);
    check_eq({tag, "_err_cnt"}, 32'(n_err - e0), ack ? 32'd0 : 32'd1);
    check_eq({tag, "_ready_at_pulse"}, 32'(pulse_ready), 32'd1);
    check_eq({tag, "_drv_at_pulse"}, 32'(pulse_drv), 32'd0);
    check_eq({tag, "_idle_ready"}, 32'(ready), 32'd1);
  endtask

  initial begin
    bit ok;
    int w;
    logic [7:0] rd;

    // Reset state.
    repeat (3) @(negedge clock);
    check_eq("rst_ready", 32'(ready), 32'd1);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_error", 32'(error), 32'd0);
    check_eq("rst_clk_drv", 32'(cdl), 32'd0);
    check_eq("rst_data_drv", 32'(ddl), 32'd0);
    reset = 1'b0;
    repeat (5) @(negedge clock);

    // Normal send of 0xED with a stray start mid-frame and a clock glitch.
    send_frame(8'hED, 1'b1, 1'b1, 1'b1, "ed");
    check_eq("ed_frame_literal", 32'(got_bits), 32'h7DA);

    // No acknowledge.
    send_frame(8'h01, 1'b0, 1'b0, 1'b0, "noack");

    // Timeout: device never clocks.
    @(negedge clock);
    start   = 1'b1;
    tx_data = 8'hA3;
    @(negedge clock);
    start = 1'b0;
    w = 0;
    while (!(cdl && ddl) && w < INHIBIT + 50) begin
      w++;
      @(negedge clock);
    end
    check_eq("to_start_seen", 32'(cdl && ddl), 32'd1);
    @(negedge clock);
    w = 0;
    while (!error && w < TIMEOUT + 100) begin
      w++;
      @(negedge clock);
    end
    check_eq("to_wait_cycles", 32'(w), 32'(TIMEOUT));
    check_eq("to_error", 32'(error), 32'd1);
    check_eq("to_done", 32'(done), 32'd0);
    check_eq("to_drives", 32'({cdl, ddl}), 32'd0);
    check_eq("to_ready", 32'(ready), 32'd1);
    @(negedge clock);
    check_eq("to_error_width", 32'(error), 32'd0);
    repeat (5) @(negedge clock);

    // Reset after the fifth device clock.
    fork
      dev_frame(5, 1'b0, 1'b0, ok);
      begin
        @(negedge clock);
        start   = 1'b1;
        tx_data = 8'h3C;
        @(negedge clock);
        start = 1'b0;
      end
    join
    check_eq("abort_request", 32'(ok), 32'd1);
    w = n_done + n_err;
    reset = 1'b1;
    @(negedge clock);
    check_eq("abort_drives", 32'({cdl, ddl}), 32'd0);
    check_eq("abort_ready", 32'(ready), 32'd1);
    check_eq("abort_pulses_now", 32'({done, error}), 32'd0);
    reset = 1'b0;
    repeat (50) @(negedge clock);
    check_eq("abort_no_pulse", 32'(n_done + n_err), 32'(w));
    send_frame(8'hFF, 1'b1, 1'b0, 1'b0, "ff");

    // Randomised frames.
    for (int i = 0; i < 3; i++) begin
      rd = 8'($urandom);
      send_frame(rd, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, "rand");
    end

    check_eq("pulse_width", 32'(n_wide), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ps2_host_transmitter.md
# ps2_host_transmitter

Host-to-device transmitter for the PS/2 port. It sends one command byte, such as LED-set 0xED or reset 0xFF, from the system to the keyboard using the PS/2 host-request protocol. It drives the open-drain clock and data lines through active-high "drive low" enables and follows the device-generated clock. It reports completion once the device acknowledges, and it shares the port with the existing keyboard receiver.

## Interface

Parameters:
- INHIBIT_CYCLES, 5000, system-clock cycles the host holds ps2_clock low (100 us at 50 MHz).
- TIMEOUT_CYCLES, 1000000, maximum system-clock cycles between request release and acknowledge. Must be < 2^20.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- ps2_clock  in  1  PS/2 clock line, read back.
- ps2_data  in  1  PS/2 data line, read back.
- start  in  1  request to send tx_data; accepted only while ready=1.
- tx_data  in  8  command byte; latched when start is accepted.
- ready  out  1  high in IDLE.
- done  out  1  one-cycle pulse: byte sent and ACK received.
- error  out  1  one-cycle pulse: no ACK, or timeout.
- ps2_clock_drive_low  out  1  1 = pull the clock line low.
- ps2_data_drive_low  out  1  1 = pull the data line low.

## Operation

- **Edge filter:** a 10-bit history register shifts in ps2_clock every cycle, newest sample in bit 9, and is cleared on reset. A falling-edge pulse fires when bits [4:0] are all 1 and bits [9:5] are all 0. Only filtered falling edges advance the FSM.
- **Frame:** 11 bits, LSB first.
  - Start bit 0.
  - d0..d7.
  - Odd parity bit, equal to ~^tx_data.
  - Stop bit 1, produced by releasing the data line.
  - The device then pulls data low as ACK.
- **Shift register:** 9 bits, holding {parity, tx_data}. It is loaded on start accept and shifts right on each DATA/PARITY edge. ps2_data_drive_low = ~shift_reg[0] while transmitting.
- **FSM:**
  - **IDLE:** both drives 0, ready=1. start=1 latches tx_data and parity, clears the bit count, goes to INHIBIT.
  - **INHIBIT:** clock drive low for exactly INHIBIT_CYCLES cycles, then go to START.
  - **START:** clock and data both driven low for 1 cycle, then go to REQUEST.
  - **REQUEST:** clock released, data low (start bit), timeout counter runs. The first falling edge presents d0 and goes to DATA.
  - **DATA:** each falling edge presents the next bit. The edge that presents the parity bit, the 9th edge overall, goes to STOP.
  - **STOP:** the 10th edge releases data (stop bit 1) and goes to ACK.
  - **ACK:** on the 11th edge, ps2_data is sampled. 0 gives done; 1 gives error. Either way go to IDLE.
  - Unused encodings go to IDLE.
- **Timeout:** a 20-bit counter clears on START entry and increments each cycle in REQUEST, DATA, STOP and ACK. Reaching TIMEOUT_CYCLES releases both lines, pulses error and returns to IDLE.
- **start handling:** start while ready=0 is ignored; tx_data changes after acceptance have no effect.
- **Reset:** reset at any time, including mid-frame, gives IDLE. Both drives are 0, done=error=0 and ready=1 at the next edge. No pulse is emitted for the aborted frame.

## Timing

- Reset values: ready=1, done=0, error=0, ps2_clock_drive_low=0, ps2_data_drive_low=0.
- start sampled at edge t: ready=0 and ps2_clock_drive_low=1 from t+1, for INHIBIT_CYCLES cycles.
- START occupies 1 cycle, then clock is released with data still low.
- Bit presentation: drive outputs update the cycle after the filtered falling-edge pulse. The filtered edge lags the raw edge by 5 cycles, well inside the device's half-period.
- done or error asserts for exactly 1 cycle, on the cycle after the 11th edge (or the timeout). ready=1 from that same cycle.
- start on the cycle done pulses is accepted, giving back-to-back frames.

## Test plan

- **Normal send:** device model clocks at 12.5 kHz, tx_data=0xED.
  - Data sampled on rising edges must read 0,1,0,1,1,0,1,1,1,1,1 (start, d0..d7, parity 1, stop).
  - Device ACKs low on clock 11 → done pulse of exactly 1 cycle, error=0.
- **No ACK:** tx_data=0x01 (parity 0); device leaves data high on clock 11 → error pulse, done=0, ready=1 the same cycle.
- **Timeout:** start, device never clocks → error exactly TIMEOUT_CYCLES cycles after START; both drives 0.
- **Inhibit length:** count the cycles ps2_clock_drive_low=1 before START → exactly INHIBIT_CYCLES.
- **Ignore start while busy, and glitch rejection:**
  - Pulse start with 0x55 mid-frame of 0xED → transmitted bits still match 0xED.
  - A 3-cycle low glitch on ps2_clock is not counted as an edge.
- **Reset mid-frame:** assert reset after edge 5 → next cycle both drives 0, ready=1, no done/error pulse.
  - A new start for 0xFF afterwards sends a correct frame with parity 1.
